// File: rtl/queue_pkg.sv
// Shared constants and helpers for the parametrised FIFO/LIFO queue.
package queue_pkg;

    localparam int unsigned QUEUE_FIFO = 0;
    localparam int unsigned QUEUE_LIFO = 1;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int unsigned len_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/queue_param_if.sv
// Data and status bundle between a queue_param instance and its user.
interface queue_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    import queue_pkg::*;

    localparam int unsigned LW = len_width(DEPTH);

    logic [WIDTH-1:0] data_in;
    logic             enq_in;
    logic             deq_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid_out;
    logic [LW-1:0]    len_out;
    logic             full_out;
    logic             empty_out;
    logic             overflow_out;
    logic             underflow_out;

    modport master (
        output data_in, enq_in, deq_in,
        input  data_out, data_valid_out, len_out, full_out, empty_out,
               overflow_out, underflow_out
    );

    modport slave (
        input  data_in, enq_in, deq_in,
        output data_out, data_valid_out, len_out, full_out, empty_out,
               overflow_out, underflow_out
    );

endinterface

// File: rtl/queue_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port.
module queue_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/queue_param.sv
// Bounded FIFO/LIFO queue with occupancy, full/empty and overflow/underflow flags.
module queue_param
    import queue_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LIFO  = QUEUE_FIFO
) (
    input logic          clock,
    input logic          reset,
    queue_param_if.slave q
);

    localparam int unsigned   LW       = len_width(DEPTH);
    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [LW-1:0]    len_q, len_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             enq_ok, deq_ok;
    logic [AW-1:0]    waddr, raddr, len_top;
    logic [WIDTH-1:0] rdata;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign deq_ok  = q.deq_in && (len_q != '0);
    assign enq_ok  = q.enq_in && ((len_q != LEN_FULL) || deq_ok);
    assign len_top = AW'(len_q - 1'b1);

    always_comb begin
        waddr    = wr_ptr_q;
        raddr    = rd_ptr_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;

        // Stack mode: a simultaneous push/pop overwrites the slot just popped.
        if (LIFO == QUEUE_LIFO) begin
            waddr = deq_ok ? len_top : AW'(len_q);
            raddr = len_top;
        end

        unique case ({enq_ok, deq_ok})
            2'b10:   len_d = len_q + 1'b1;
            2'b01:   len_d = len_q - 1'b1;
            default: len_d = len_q;
        endcase

        if (enq_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (deq_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            data_d   = rdata;
        end

        valid_d = deq_ok;
        ovf_d   = q.enq_in && !enq_ok;
        udf_d   = q.deq_in && (len_q == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    queue_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clock(clock),
        .we   (enq_ok),
        .waddr(waddr),
        .wdata(q.data_in),
        .raddr(raddr),
        .rdata(rdata)
    );

    assign q.data_out       = data_q;
    assign q.data_valid_out = valid_q;
    assign q.len_out        = len_q;
    assign q.full_out       = (len_q == LEN_FULL);
    assign q.empty_out      = (len_q == '0);
    assign q.overflow_out   = ovf_q;
    assign q.underflow_out  = udf_q;

endmodule

// File: tb/tb_queue_param.sv
// Scoreboard bench: three queue_param configurations (FIFO/8, FIFO/5, LIFO/8).
module tb_queue_param;
    import queue_pkg::*;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] din   [3];
    logic       enq   [3];
    logic       deq   [3];
    logic [7:0] dout  [3];
    logic       dv    [3];
    logic       full  [3];
    logic       empty [3];
    logic       ovf   [3];
    logic       udf   [3];
    logic [3:0] len   [3];
    logic [7:0] exp_q [3][$];

    queue_param_if #(.WIDTH(8), .DEPTH(8)) if0 ();
    queue_param_if #(.WIDTH(8), .DEPTH(5)) if1 ();
    queue_param_if #(.WIDTH(8), .DEPTH(8)) if2 ();

    queue_param #(.WIDTH(8), .DEPTH(8), .LIFO(QUEUE_FIFO)) dut_f8 (
        .clock(clock), .reset(rst_n), .q(if0));
    queue_param #(.WIDTH(8), .DEPTH(5), .LIFO(QUEUE_FIFO)) dut_f5 (
        .clock(clock), .reset(rst_n), .q(if1));
    queue_param #(.WIDTH(8), .DEPTH(8), .LIFO(QUEUE_LIFO)) dut_l8 (
        .clock(clock), .reset(rst_n), .q(if2));

    assign if0.data_in = din[0]; assign if0.enq_in = enq[0]; assign if0.deq_in = deq[0];
    assign if1.data_in = din[1]; assign if1.enq_in = enq[1]; assign if1.deq_in = deq[1];
    assign if2.data_in = din[2]; assign if2.enq_in = enq[2]; assign if2.deq_in = deq[2];

    assign dout[0] = if0.data_out;  assign dv[0] = if0.data_valid_out;
    assign dout[1] = if1.data_out;  assign dv[1] = if1.data_valid_out;
    assign dout[2] = if2.data_out;  assign dv[2] = if2.data_valid_out;
    assign len[0]  = 4'(if0.len_out);
    assign len[1]  = 4'(if1.len_out);
    assign len[2]  = 4'(if2.len_out);
    assign full[0] = if0.full_out;  assign empty[0] = if0.empty_out;
    assign full[1] = if1.full_out;  assign empty[1] = if1.empty_out;
    assign full[2] = if2.full_out;  assign empty[2] = if2.empty_out;
    assign ovf[0]  = if0.overflow_out; assign udf[0] = if0.underflow_out;
    assign ovf[1]  = if1.overflow_out; assign udf[1] = if1.underflow_out;
    assign ovf[2]  = if2.overflow_out; assign udf[2] = if2.underflow_out;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One clock of stimulus on instance i; returns 1 time unit after the edge.
    task automatic cycle(input int i, input bit e, input bit d, input logic [7:0] v);
        din[i] = v;
        enq[i] = e;
        deq[i] = d;
        @(posedge clock);
        #1;
        enq[i] = 1'b0;
        deq[i] = 1'b0;
    endtask

    task automatic pop(input int i, input logic [7:0] v);
        exp_q[i].push_back(v);
        cycle(i, 1'b0, 1'b1, 8'h00);
    endtask

    // Monitor: every data_valid_out pulse must match the oldest expected word.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (dv[i]) begin
                n_tests++;
                if (exp_q[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid dut%0d: got 0x%0h, expected no output",
                             i, dout[i]);
                end else begin
                    logic [7:0] e;
                    e = exp_q[i].pop_front();
                    if (dout[i] !== e) begin
                        n_fail++;
                        $display("FAIL dout dut%0d: got 0x%0h, expected 0x%0h", i, dout[i], e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            enq[i] = 1'b0;
            deq[i] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        chk("reset_len", len[0], 0);
        chk("reset_empty", empty[0], 1);
        chk("reset_full", full[0], 0);
        chk("reset_dout", dout[0], 0);
        chk("reset_valid", dv[0], 0);
        chk("reset_flags", {ovf[0], udf[0]}, 0);
        #2 rst_n = 1'b1;

        // FIFO basic order
        cycle(0, 1'b1, 1'b0, 8'h11);
        cycle(0, 1'b1, 1'b0, 8'h22);
        cycle(0, 1'b1, 1'b0, 8'h33);
        chk("fifo_len3", len[0], 3);
        chk("fifo_not_empty", empty[0], 0);
        pop(0, 8'h11);
        chk("fifo_valid_pulse", dv[0], 1);
        chk("fifo_len2", len[0], 2);
        pop(0, 8'h22);
        pop(0, 8'h33);
        chk("fifo_len0", len[0], 0);
        chk("fifo_empty_end", empty[0], 1);

        // Fill past capacity, then enq+deq while full
        for (int k = 1; k <= 8; k++) cycle(0, 1'b1, 1'b0, 8'(k));
        chk("full_len8", len[0], 8);
        chk("full_flag", full[0], 1);
        chk("full_no_ovf", ovf[0], 0);
        cycle(0, 1'b1, 1'b0, 8'h09);
        chk("ovf_pulse", ovf[0], 1);
        chk("ovf_len8", len[0], 8);
        exp_q[0].push_back(8'h01);
        cycle(0, 1'b1, 1'b1, 8'h0A);
        chk("full_both_ovf", ovf[0], 0);
        chk("full_both_len", len[0], 8);
        for (int k = 2; k <= 8; k++) pop(0, 8'(k));
        pop(0, 8'h0A);
        chk("drain_len0", len[0], 0);

        // Non-power-of-two depth with pointer wrap
        for (int k = 0; k < 3; k++) cycle(1, 1'b1, 1'b0, 8'(8'h31 + k));
        for (int k = 0; k < 3; k++) pop(1, 8'(8'h31 + k));
        for (int k = 0; k < 5; k++) cycle(1, 1'b1, 1'b0, 8'(8'hA0 + k));
        chk("d5_len5", len[1], 5);
        chk("d5_full", full[1], 1);
        for (int k = 0; k < 5; k++) pop(1, 8'(8'hA0 + k));
        chk("d5_empty", empty[1], 1);

        // LIFO
        cycle(2, 1'b1, 1'b0, 8'h10);
        cycle(2, 1'b1, 1'b0, 8'h20);
        cycle(2, 1'b1, 1'b0, 8'h30);
        pop(2, 8'h30);
        chk("lifo_len2", len[2], 2);
        exp_q[2].push_back(8'h20);
        cycle(2, 1'b1, 1'b1, 8'h40);
        chk("lifo_both_len", len[2], 2);
        pop(2, 8'h40);
        pop(2, 8'h10);
        chk("lifo_len0", len[2], 0);

        // Empty boundary
        cycle(0, 1'b0, 1'b1, 8'h00);
        chk("udf_pulse", udf[0], 1);
        chk("udf_no_valid", dv[0], 0);
        chk("udf_dout_hold", dout[0], 8'h0A);
        cycle(0, 1'b0, 1'b0, 8'h00);
        chk("udf_not_sticky", udf[0], 0);
        cycle(0, 1'b1, 1'b1, 8'h55);
        chk("empty_both_len", len[0], 1);
        chk("empty_both_udf", udf[0], 1);
        chk("empty_both_no_bypass", dout[0], 8'h0A);
        pop(0, 8'h55);
        chk("empty_both_len0", len[0], 0);

        // Reset mid-operation
        for (int k = 0; k < 5; k++) cycle(0, 1'b1, 1'b0, 8'(8'hC1 + k));
        pop(0, 8'hC1);
        chk("pre_reset_len", len[0], 4);
        #5 rst_n = 1'b0;
        #1;
        chk("midreset_len", len[0], 0);
        chk("midreset_empty", empty[0], 1);
        chk("midreset_dout", dout[0], 0);
        #2 rst_n = 1'b1;
        cycle(0, 1'b0, 1'b1, 8'h00);
        chk("post_reset_udf", udf[0], 1);
        chk("post_reset_len", len[0], 0);

        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("leftover_dut%0d", i), exp_q[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/queue_param.md
Name: queue_param

Overview:
Parametrised successor to the fixed 8x8 queue in the deserialiser datapath. Bounded buffer of DEPTH words of WIDTH bits, selectable at elaboration as FIFO or LIFO. Elements enter via data_in/enq_in and leave via deq_in; the removed word appears registered on data_out one cycle later. Adds occupancy, full/empty, overflow/underflow flags and simultaneous enqueue/dequeue, which the original block lacks. Runs at 10 kHz in the system, with no timing dependence on that rate.

Parameters:
WIDTH, 8, bits per element (>=1)
DEPTH, 8, number of entries (>=2, need not be a power of two)
LIFO, 0, 0 = FIFO order, 1 = LIFO (stack) order

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
data_in  input  WIDTH  element to insert
enq_in  input  1  insert data_in this cycle
deq_in  input  1  remove one element this cycle
data_out  output  WIDTH  last removed element, registered
data_valid_out  output  1  1-cycle pulse: data_out updated by a successful dequeue
len_out  output  $clog2(DEPTH+1)  number of occupied entries, 0..DEPTH
full_out  output  1  len_out == DEPTH
empty_out  output  1  len_out == 0
overflow_out  output  1  1-cycle pulse: enqueue rejected
underflow_out  output  1  1-cycle pulse: dequeue on empty

Behaviour:
- Reset (reset low, async): len_out=0, wr/rd pointers=0, data_out=0, data_valid_out=0, empty_out=1, full_out=0, overflow_out=0, underflow_out=0. Storage contents are not reset and not observable. Reset mid-operation discards all contents. Deassertion takes effect on the next rising edge.
- All state updates on the rising edge of clock. Inputs are sampled at that edge.
- Dequeue accepted iff deq_in=1 and len>0. At that edge data_out <= selected element and data_valid_out <= 1. Latency is 1 cycle. Otherwise data_valid_out <= 0 and data_out holds its value.
- Enqueue accepted iff enq_in=1 and (len<DEPTH, or a dequeue is accepted in the same cycle).
- Rejected enqueue: storage and len unchanged, overflow_out <= 1 for one cycle.
- deq_in=1 with len=0: underflow_out <= 1 for one cycle, data_out unchanged, data_valid_out <= 0.
- Flags are 0 in every cycle without the event. They are not sticky.
- FIFO mode: circular buffer.
  - wr_ptr advances on accepted enqueue; rd_ptr advances on accepted dequeue.
  - Each pointer wraps from DEPTH-1 to 0 explicitly; no power-of-two assumption.
  - Dequeue returns mem[rd_ptr].
- LIFO mode: stack indexed by len.
  - Push writes mem[len]; pop returns mem[len-1].
  - Simultaneous push and pop with len>0: output is old top; new word is written to mem[len-1]; len unchanged.
- Simultaneous enq+deq:
  - len>0, either mode, including full: both accepted, len unchanged, no overflow.
  - len=0: enqueue accepted, dequeue reports underflow, no bypass of data_in to data_out; len becomes 1.
- len_out update: +1 for enqueue only, -1 for dequeue only, 0 for both or neither. Never exceeds DEPTH and never wraps below 0.
- full_out/empty_out are derived from the registered len, so they are valid in the same cycle as len_out.
- No FSM beyond the pointer/len registers; occupancy states are EMPTY (len=0), PARTIAL, FULL (len=DEPTH).

Decomposition:
- Package queue_pkg: mode constants QUEUE_FIFO=0 and QUEUE_LIFO=1; a function returning the len width for a given DEPTH.
- Sub-module queue_mem: DEPTH x WIDTH register file, one synchronous write port (we, waddr, wdata), one combinational read port (raddr -> rdata), no reset.
- queue_param holds pointers, len, flags and the output register.

Test Plan:
- FIFO, defaults: reset, enqueue 0x11,0x22,0x33, then dequeue x3 -> data_out 0x11,0x22,0x33 one cycle after each deq_in, data_valid_out pulses; len_out 3->0; empty_out=1 at end.
- FIFO, DEPTH=8: enqueue 9 words 0x01..0x09 -> len_out=8, full_out=1, overflow_out pulses on the 9th; then drain 8 -> 0x01..0x08, 0x09 never appears.
- FIFO, DEPTH=5 (non-power-of-two) wrap: 3 enq/3 deq, then 5 enq/5 deq of 0xA0..0xA4 -> order preserved across pointer wrap, len_out peaks at 5.
- LIFO: push 0x10,0x20,0x30, then pop -> 0x30; simultaneous push 0x40 + pop -> data_out 0x20, len_out stays 2; pop x2 -> 0x40, 0x10.
- Empty boundary: deq_in with len=0 -> underflow_out=1, data_valid_out=0, data_out unchanged; simultaneous enq 0x55 + deq on empty -> len_out=1, underflow_out=1, next deq -> 0x55.
- Reset mid-operation: fill 4 words, pull reset low between edges -> len_out=0, empty_out=1, data_out=0 immediately; after release, deq_in -> underflow_out=1.
